// File: rtl/sincos_pkg.sv
// Shared constants, FSM state type and phase helpers for the sin/cos angle sweep.
// The sin pipeline wrapper also uses these.
package sincos_pkg;

  localparam int W                   = 27;
  localparam int DEFAULT_SIN_LATENCY = 20;

  // Angles are Q.8 fixed point, so PI is 3.14159 * 256.
  localparam int PI      = 804;
  localparam int HALF_PI = 402;
  localparam int TWO_PI  = 1608;

  localparam logic signed [W-1:0] PI_N      = W'(PI);
  localparam logic signed [W-1:0] HALF_PI_N = W'(HALF_PI);
  localparam logic signed [W:0]   PI_X      = (W+1)'(PI);
  localparam logic signed [W:0]   TWO_PI_X  = (W+1)'(TWO_PI);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sweep_state_t;

  // The operand range checks keep every sum within one period of [-PI, PI),
  // so a single correction always brings it back into range.
  function automatic logic signed [W-1:0] wrap_phase(input logic signed [W:0] x);
    logic signed [W:0] r;
    if (x >= PI_X)
      r = x - TWO_PI_X;
    else if (x < -PI_X)
      r = x + TWO_PI_X;
    else
      r = x;
    return r[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] add_wrap(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    return wrap_phase(s);
  endfunction

  function automatic logic in_range(input logic signed [W-1:0] x);
    return (x >= -PI_N) && (x < PI_N);
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register for sideband flags that must stay aligned with
// the sin pipeline. It shifts every cycle and is cleared by the async reset.
module valid_delay_line #(
  parameter int DEPTH = 20,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sincos_sweep.sv
// Swept-phase generator that feeds a sin/cos pair of sin pipelines and tracks
// sample validity through the fixed pipeline latency. Angle width comes from sincos_pkg.
module sincos_sweep
  import sincos_pkg::*;
#(
  parameter int N_W         = 16,
  parameter int SIN_LATENCY = DEFAULT_SIN_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] phase_start,
  input  logic signed [W-1:0] phase_step,
  input  logic [N_W-1:0]      num_samples,
  output logic                sin_en,
  output logic signed [W-1:0] angle_sin,
  output logic signed [W-1:0] angle_cos,
  output logic                angle_valid,
  output logic                result_valid,
  output logic                result_last,
  output logic                busy,
  output logic                done,
  output logic                err
);

  sweep_state_t state, state_next;

  logic signed [W-1:0] phase;
  logic signed [W-1:0] step;
  logic [N_W-1:0]      remaining;
  logic                angle_last;
  logic                done_zero;
  logic                accept;
  logic                reject;
  logic                zero_req;
  logic [1:0]          flags_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // A start is only looked at in IDLE; DRAIN leaves once the final sample
  // has emerged from the sin pipeline.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    zero_req   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!in_range(phase_start) || !in_range(phase_step)) begin
            reject = 1'b1;
          end else if (num_samples == '0) begin
            zero_req = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = (num_samples == N_W'(1)) ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (remaining == N_W'(1))
          state_next = DRAIN;
      end
      DRAIN: begin
        if (result_last)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The first sample is emitted on the accepting edge so it appears the
  // cycle after start; RUN then emits the rest back-to-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sin_en      <= 1'b0;
      angle_sin   <= '0;
      angle_cos   <= '0;
      angle_valid <= 1'b0;
      angle_last  <= 1'b0;
      phase       <= '0;
      step        <= '0;
      remaining   <= '0;
      err         <= 1'b0;
      done_zero   <= 1'b0;
    end else begin
      sin_en      <= 1'b1;
      err         <= reject;
      done_zero   <= zero_req;
      angle_valid <= 1'b0;
      angle_last  <= 1'b0;
      if (accept) begin
        angle_sin   <= phase_start;
        angle_cos   <= add_wrap(phase_start, HALF_PI_N);
        angle_valid <= 1'b1;
        angle_last  <= (num_samples == N_W'(1));
        phase       <= add_wrap(phase_start, phase_step);
        step        <= phase_step;
        remaining   <= num_samples - N_W'(1);
      end else if (state == RUN) begin
        angle_sin   <= phase;
        angle_cos   <= add_wrap(phase, HALF_PI_N);
        angle_valid <= 1'b1;
        angle_last  <= (remaining == N_W'(1));
        phase       <= add_wrap(phase, step);
        remaining   <= remaining - N_W'(1);
      end
    end
  end

  valid_delay_line #(
    .DEPTH (SIN_LATENCY),
    .WIDTH (2)
  ) u_flag_delay (
    .clk   (clk),
    .rst_n (rst),
    .din   ({angle_valid, angle_last}),
    .dout  (flags_out)
  );

  assign result_valid = flags_out[1];
  assign result_last  = flags_out[0];

  assign busy = (state != IDLE);
  assign done = done_zero | ((state == DRAIN) && result_last);

endmodule

// File: tb/tb_sincos_sweep.sv
// Directed bench for sincos_sweep: a scoreboard of expected angles, results,
// done/err pulses and busy windows is checked against the DUT every cycle.
module tb_sincos_sweep;

  localparam int W       = 27;
  localparam int N_W     = 16;
  localparam int LAT     = 20;
  localparam int PI      = 804;
  localparam int HALF_PI = 402;
  localparam int TWO_PI  = 1608;

  typedef struct {
    int cyc;
    int sinV;
    int cosV;
  } angEntry_t;

  typedef struct {
    int cyc;
    bit last;
  } resEntry_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic signed [W-1:0] phase_start = '0;
  logic signed [W-1:0] phase_step = '0;
  logic [N_W-1:0]      num_samples = '0;
  logic                sin_en;
  logic signed [W-1:0] angle_sin;
  logic signed [W-1:0] angle_cos;
  logic                angle_valid;
  logic                result_valid;
  logic                result_last;
  logic                busy;
  logic                done;
  logic                err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit monitorOn = 0;
  int busyFrom = 1;
  int busyTo = 0;

  angEntry_t angQ[$];
  resEntry_t resQ[$];
  int doneQ[$];
  int errQ[$];

  sincos_sweep #(
    .N_W         (N_W),
    .SIN_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .phase_start  (phase_start),
    .phase_step   (phase_step),
    .num_samples  (num_samples),
    .sin_en       (sin_en),
    .angle_sin    (angle_sin),
    .angle_cos    (angle_cos),
    .angle_valid  (angle_valid),
    .result_valid (result_valid),
    .result_last  (result_last),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wrapModel(input int x);
    if (x >= PI) return x - TWO_PI;
    if (x < -PI) return x + TWO_PI;
    return x;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1ns after a rising edge; start is held for exactly one cycle.
  task automatic applyStimulus(input int ps, input int st, input int n);
    int t;
    int p;
    bool_check: begin end
    t = cyc;
    phase_start = W'(ps);
    phase_step  = W'(st);
    num_samples = N_W'(n);
    start       = 1'b1;
    if (cyc >= busyFrom && cyc <= busyTo) begin
      $display("[TB] start at cycle %0d while busy, expecting it ignored", t);
    end else if (ps < -PI || ps >= PI || st < -PI || st >= PI) begin
      errQ.push_back(t + 1);
    end else if (n == 0) begin
      doneQ.push_back(t + 1);
    end else begin
      p = ps;
      for (int k = 0; k < n; k++) begin
        angQ.push_back('{cyc: t + 1 + k, sinV: p, cosV: wrapModel(p + HALF_PI)});
        resQ.push_back('{cyc: t + 1 + LAT + k, last: (k == n - 1)});
        p = wrapModel(p + st);
      end
      doneQ.push_back(t + LAT + n);
      busyFrom = t + 1;
      busyTo   = t + LAT + n;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_sin_en"}, sin_en, 0);
    checkOutput({tag, "_angle_sin"}, angle_sin, 0);
    checkOutput({tag, "_angle_cos"}, angle_cos, 0);
    checkOutput({tag, "_angle_valid"}, angle_valid, 0);
    checkOutput({tag, "_result_valid"}, result_valid, 0);
    checkOutput({tag, "_result_last"}, result_last, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  // Per-cycle scoreboard comparison on the falling edge.
  always @(negedge clk) begin
    angEntry_t a;
    resEntry_t r;
    bit doneExp;
    bit errExp;
    if (monitorOn) begin
      if (angQ.size() > 0 && angQ[0].cyc == cyc) begin
        a = angQ.pop_front();
        checkOutput("angle_valid", angle_valid, 1);
        checkOutput("angle_sin", angle_sin, a.sinV);
        checkOutput("angle_cos", angle_cos, a.cosV);
      end else begin
        checkOutput("angle_valid_idle", angle_valid, 0);
      end
      if (resQ.size() > 0 && resQ[0].cyc == cyc) begin
        r = resQ.pop_front();
        checkOutput("result_valid", result_valid, 1);
        checkOutput("result_last", result_last, r.last);
      end else begin
        checkOutput("result_valid_idle", result_valid, 0);
        checkOutput("result_last_idle", result_last, 0);
      end
      doneExp = (doneQ.size() > 0 && doneQ[0] == cyc);
      if (doneExp) void'(doneQ.pop_front());
      checkOutput("done", done, doneExp);
      errExp = (errQ.size() > 0 && errQ[0] == cyc);
      if (errExp) void'(errQ.pop_front());
      checkOutput("err", err, errExp);
      checkOutput("busy", busy, (cyc >= busyFrom && cyc <= busyTo));
    end
  end

  initial begin
    int t;
    $display("[TB] reset phase");
    #23;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("sin_en_after_release", sin_en, 1);
    monitorOn = 1;
    waitCycles(2);

    $display("[TB] basic sweep");
    applyStimulus(0, 100, 4);
    waitCycles(LAT + 6);

    $display("[TB] positive wrap");
    applyStimulus(700, 200, 3);
    waitCycles(LAT + 5);

    $display("[TB] negative wrap");
    applyStimulus(-700, -200, 2);
    waitCycles(LAT + 4);

    $display("[TB] range errors");
    applyStimulus(804, 0, 1);
    waitCycles(3);
    applyStimulus(0, -805, 1);
    waitCycles(3);
    applyStimulus(-804, 803, 1);
    waitCycles(LAT + 3);

    $display("[TB] zero samples and start while busy");
    applyStimulus(0, 100, 0);
    waitCycles(3);
    applyStimulus(-300, 250, 4);
    waitCycles(2);
    applyStimulus(500, 5, 3);
    waitCycles(LAT + 4);

    $display("[TB] reset mid-run");
    t = cyc;
    applyStimulus(0, 50, 8);
    waitCycles(2);
    checkOutput("pre_reset_cycle", cyc, t + 3);
    rst = 1'b0;
    angQ.delete();
    resQ.delete();
    doneQ.delete();
    errQ.delete();
    busyFrom = 1;
    busyTo   = 0;
    #1;
    checkAllZero("midrun_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("sin_en_after_rerelease", sin_en, 1);
    waitCycles(40);
    applyStimulus(100, 10, 1);
    waitCycles(LAT + 4);

    monitorOn = 0;
    checkOutput("angq_drained", angQ.size(), 0);
    checkOutput("resq_drained", resQ.size(), 0);
    checkOutput("doneq_drained", doneQ.size(), 0);
    checkOutput("errq_drained", errQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
